mux_16_1_3b: RTL and testbench
==============================

MUX_16_1_3B -- requirements
Module: mux_16_1_3b

Interface
REQ-001 Parameter N_CH, default 12, number of populated input channels (1..16).
REQ-002 Parameter W, default 3, bit width of each channel.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 Port SEL, input, 4, channel select index.
REQ-006 Port entradas, input, N_CH*W (36), packed channel bus; channel i occupies bits [W*i+W-1 : W*i].
REQ-007 Port salida, output, W (3), selected channel data, registered.
REQ-008 Port sel_err, output, 1, registered flag for out-of-range SEL; present only with MUX16_SEL_ERR_EN.

Function
REQ-009 The block SHALL register, on every rising clk edge, salida <= channel SEL of entradas when SEL < N_CH.
REQ-010 The block SHALL load salida <= 0 when SEL >= N_CH (default indices 12..15).
REQ-011 Latency SHALL be exactly one clock cycle from SEL or entradas change to salida update; there is no enable and no handshake.
REQ-012 Changes on SEL/entradas between edges SHALL have no effect on salida until the next rising edge.
REQ-013 SEL wrap-around from 15 to 0 SHALL select channel 0 with no special handling.
REQ-014 An X/undefined SEL is not a supported input; the block is not required to handle it.
REQ-015 Selection SHALL be a full 16-way decode of SEL, not a priority chain; unused codes are handled per REQ-010.

Reset
REQ-016 While rst_n is low, salida SHALL be 0 (and sel_err SHALL be 0) immediately, independent of clk.
REQ-017 Once rst_n deasserts, the first rising edge SHALL load the selection per REQ-009/REQ-010.
REQ-018 Reset asserted mid-operation SHALL clear the outputs asynchronously; no other state exists.

Configuration
REQ-019 With macro MUX16_SEL_ERR_EN defined, port sel_err SHALL exist and SHALL register 1 when SEL >= N_CH, else 0, with the same timing as salida.
REQ-020 Without MUX16_SEL_ERR_EN, port sel_err and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-021 Shared package mux_pkg SHALL hold the constants SEL_W = 4, MAX_CH = 16, default N_CH = 12, default W = 3.
REQ-022 Combinational selection SHALL be one sub-module, mux_sel_comb (SEL, entradas -> selected data, out-of-range flag); the top adds the output registers only.
REQ-023 An elaboration check SHALL reject N_CH > 16 or W < 1.

Verification
Test vector: entradas = 36'b010010110100101101001010101001010010, which gives channels 0..11 = 2, 2, 1, 5, 2, 1, 5, 5, 4, 6, 2, 2.
REQ-024 Hold rst_n low and toggle SEL -> salida = 0 (sel_err = 0) throughout.
REQ-025 Release reset with SEL = 0, then increment SEL every 2 clocks through 0..11 -> salida, one cycle later, = 2, 2, 1, 5, 2, 1, 5, 5, 4, 6, 2, 2.
REQ-026 SEL = 12..15 -> salida = 0 one cycle later; with MUX16_SEL_ERR_EN, sel_err = 1; SEL then wraps to 0 -> salida = 2 and sel_err = 0.
REQ-027 SEL = 9 steady; change entradas channel 9 from 6 to 7 mid-cycle -> salida stays 6 until the next edge, then becomes 7.
REQ-028 SEL = 3 with salida = 5; assert rst_n asynchronously between edges -> salida = 0 at once; deassert -> salida = 5 after the next edge.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the 16:1 registered channel multiplexer family.
package mux_pkg;

   localparam int SEL_W    = 4;
   localparam int MAX_CH   = 16;
   localparam int DEF_N_CH = 12;
   localparam int DEF_W    = 3;

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational 16-way channel decode; unpopulated channels read as zero.
// Optional out-of-range flag output exists only with MUX16_SEL_ERR_EN.
module mux_sel_comb
   import mux_pkg::*;
#(
   parameter int N_CH = DEF_N_CH,
   parameter int W    = DEF_W
) (
   input  logic [SEL_W-1:0]  sel,
   input  logic [N_CH*W-1:0] entradas,
   output logic [W-1:0]      data
`ifdef MUX16_SEL_ERR_EN
   ,
   output logic              err
`endif
);

   logic [W-1:0] chan [MAX_CH];

   // Pad the populated channels out to a full 16-entry table so every SEL code decodes directly.
   generate
      for (genvar i = 0; i < MAX_CH; i++) begin : g_chan
         if (i < N_CH) begin : g_used
            assign chan[i] = entradas[W*i +: W];
         end else begin : g_unused
            assign chan[i] = '0;
         end
      end
   endgenerate

   assign data = chan[sel];

`ifdef MUX16_SEL_ERR_EN
   localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(N_CH);
   assign err = ({1'b0, sel} >= NCH_L);
`endif

endmodule

// File: rtl/mux_16_1_3b.sv
// Registered 16:1 multiplexer of N_CH channels of W bits, one cycle latency.
// Define MUX16_SEL_ERR_EN to add the registered out-of-range flag sel_err.
module mux_16_1_3b
   import mux_pkg::*;
#(
   parameter int N_CH = DEF_N_CH,
   parameter int W    = DEF_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SEL_W-1:0]  SEL,
   input  logic [N_CH*W-1:0] entradas,
   output logic [W-1:0]      salida
`ifdef MUX16_SEL_ERR_EN
   ,
   output logic              sel_err
`endif
);

   generate
      if (N_CH < 1 || N_CH > MAX_CH || W < 1) begin : g_bad_cfg
         $error("mux_16_1_3b: N_CH must be 1..16 and W must be >= 1");
      end
   endgenerate

   logic [W-1:0] sel_data;
`ifdef MUX16_SEL_ERR_EN
   logic         sel_oor;
`endif

   mux_sel_comb #(
      .N_CH (N_CH),
      .W    (W)
   ) u_sel (
      .sel      (SEL),
      .entradas (entradas),
      .data     (sel_data)
`ifdef MUX16_SEL_ERR_EN
      ,
      .err      (sel_oor)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         salida <= '0;
      end else begin
         salida <= sel_data;
      end
   end

`ifdef MUX16_SEL_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else begin
         sel_err <= sel_oor;
      end
   end
`endif

endmodule

// File: tb/tb_mux_16_1_3b.sv
// Scoreboard bench for mux_16_1_3b; also exercises sel_err when MUX16_SEL_ERR_EN is defined.
module tb_mux_16_1_3b;

   localparam logic [35:0] VEC = 36'b010010110100101101001010101001010010;

   typedef struct packed {
      logic [2:0] d;
      logic       e;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  SEL;
   logic [35:0] entradas;
   logic [2:0]  salida;
`ifdef MUX16_SEL_ERR_EN
   logic        sel_err;
`endif

   exp_t       sb [$];
   exp_t       got;
   int         total = 0;
   int         bad   = 0;
   logic [2:0] exp_tab [12];

   mux_16_1_3b dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SEL      (SEL),
      .entradas (entradas),
      .salida   (salida)
`ifdef MUX16_SEL_ERR_EN
      ,
      .sel_err  (sel_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference: channels 0..11 populated, 12..15 read zero.
   function automatic exp_t model(input logic [3:0] s, input logic [35:0] ent);
      exp_t r;
      r.d = 3'd0;
      r.e = 1'b1;
      if (s < 4'd12) begin
         r.d = ent[3*s +: 3];
         r.e = 1'b0;
      end
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if (salida !== 3'd0) begin
         bad++;
         $display("FAIL reset_immediate: salida=%0d expected=0", salida);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         SEL = 4'(i * 3);
         sb.push_back('{d: 3'd0, e: 1'b0});
         @(posedge clk);
         #1;
         got = sb.pop_front();
         total++;
         if (salida !== got.d) begin
            bad++;
            $display("FAIL reset_hold: salida=%0d expected=%0d", salida, got.d);
         end
`ifdef MUX16_SEL_ERR_EN
         total++;
         if (sel_err !== got.e) begin
            bad++;
            $display("FAIL reset_hold_err: sel_err=%0b expected=%0b", sel_err, got.e);
         end
`endif
      end
   endtask

   task automatic test_sweep();
      for (int s = 0; s < 12; s++) begin
         for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk);
            if (s == 0 && rep == 0) rst_n = 1'b1;
            SEL = 4'(s);
            sb.push_back('{d: exp_tab[s], e: 1'b0});
            @(posedge clk);
            #1;
            got = sb.pop_front();
            total++;
            if (salida !== got.d) begin
               bad++;
               $display("FAIL sweep sel=%0d: salida=%0d expected=%0d", s, salida, got.d);
            end
`ifdef MUX16_SEL_ERR_EN
            total++;
            if (sel_err !== got.e) begin
               bad++;
               $display("FAIL sweep_err sel=%0d: sel_err=%0b expected=%0b", s, sel_err, got.e);
            end
`endif
         end
      end
   endtask

   task automatic test_out_of_range();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         SEL = SEL + 4'd1;
         if (k < 4) sb.push_back('{d: 3'd0, e: 1'b1});
         else       sb.push_back('{d: 3'd2, e: 1'b0});
         @(posedge clk);
         #1;
         got = sb.pop_front();
         total++;
         if (salida !== got.d) begin
            bad++;
            $display("FAIL range sel=%0d: salida=%0d expected=%0d", SEL, salida, got.d);
         end
`ifdef MUX16_SEL_ERR_EN
         total++;
         if (sel_err !== got.e) begin
            bad++;
            $display("FAIL range_err sel=%0d: sel_err=%0b expected=%0b", SEL, sel_err, got.e);
         end
`endif
      end
   endtask

   task automatic test_mid_cycle();
      @(negedge clk);
      SEL = 4'd9;
      sb.push_back('{d: 3'd6, e: 1'b0});
      @(posedge clk);
      #1;
      got = sb.pop_front();
      total++;
      if (salida !== got.d) begin
         bad++;
         $display("FAIL mid_pre: salida=%0d expected=%0d", salida, got.d);
      end
      #2;
      entradas[29:27] = 3'd7;
      #1;
      total++;
      if (salida !== 3'd6) begin
         bad++;
         $display("FAIL mid_hold: salida=%0d expected=6", salida);
      end
      sb.push_back('{d: 3'd7, e: 1'b0});
      @(posedge clk);
      #1;
      got = sb.pop_front();
      total++;
      if (salida !== got.d) begin
         bad++;
         $display("FAIL mid_post: salida=%0d expected=%0d", salida, got.d);
      end
      @(negedge clk);
      entradas = VEC;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      SEL = 4'd3;
      sb.push_back('{d: 3'd5, e: 1'b0});
      @(posedge clk);
      #1;
      got = sb.pop_front();
      total++;
      if (salida !== got.d) begin
         bad++;
         $display("FAIL arst_pre: salida=%0d expected=%0d", salida, got.d);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (salida !== 3'd0) begin
         bad++;
         $display("FAIL arst_clear: salida=%0d expected=0", salida);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{d: 3'd5, e: 1'b0});
      @(posedge clk);
      #1;
      got = sb.pop_front();
      total++;
      if (salida !== got.d) begin
         bad++;
         $display("FAIL arst_post: salida=%0d expected=%0d", salida, got.d);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         SEL      = 4'($urandom_range(0, 15));
         entradas = {4'($urandom), $urandom};
         sb.push_back(model(SEL, entradas));
         @(posedge clk);
         #1;
         got = sb.pop_front();
         total++;
         if (salida !== got.d) begin
            bad++;
            $display("FAIL b2b sel=%0d: salida=%0d expected=%0d", SEL, salida, got.d);
         end
`ifdef MUX16_SEL_ERR_EN
         total++;
         if (sel_err !== got.e) begin
            bad++;
            $display("FAIL b2b_err sel=%0d: sel_err=%0b expected=%0b", SEL, sel_err, got.e);
         end
`endif
      end
   endtask

   initial begin
      exp_tab  = '{3'd2, 3'd2, 3'd1, 3'd5, 3'd2, 3'd1, 3'd5, 3'd5, 3'd4, 3'd6, 3'd2, 3'd2};
      SEL      = 4'd0;
      entradas = VEC;
      rst_n    = 1'b0;
      test_reset();
      test_sweep();
      test_out_of_range();
      test_mid_cycle();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
